// File: rtl/host_bridge_pkg.sv
// host_bridge_pkg: shared types and constants for the host byte bridge.
//   state_t       - bridge FSM states
//   CMD_WR_BIT    - command byte bit selecting write (1) or read (0)
//   BYTES_PER_REG - byte lanes per 32-bit register
//   LANE_LAST     - index of the final byte lane in a frame
package host_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_LOAD = 2'd2,
    RD_SEND = 2'd3
  } state_t;

  localparam int unsigned CMD_WR_BIT    = 7;
  localparam int unsigned BYTES_PER_REG = 4;
  localparam logic [1:0]  LANE_LAST     = 2'd3;

endpackage

// File: rtl/host_bridge_timer.sv
// host_bridge_timer: loadable down-counter with a registered expiry pulse.
// The pulse appears exactly CYCLES cycles after the cycle in which load was
// asserted, provided en stays high and no further load occurs. CYCLES >= 2.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - restart the count
//   en        - count enable
//   expired   - one-cycle registered expiry pulse
module host_bridge_timer #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  // Count down to zero; the pulse is registered on the 1->0 step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (load) begin
        cnt <= CW'(CYCLES - 1);
      end else if (en && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/host_byte_bridge.sv
// host_byte_bridge: host byte-stream command decoder for a byte-enable
// register bank. A command byte (bit 7 = write, low bits = register index)
// is followed by four data bytes (writes) or returns four bytes on the tx
// stream (reads), LSB lane first.
// Optional inter-byte write timeout compiled in with HOST_BRIDGE_TIMEOUT_EN.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   rx_valid/rx_data/rx_ready - host byte input stream
//   tx_valid/tx_data/tx_ready - read byte output stream
//   reg_addr, byte_sel   - register index and byte lane
//   byte_wdata, reg_we   - write byte and one-cycle write strobe
//   byte_rdata           - combinational read of the selected lane
//   busy                 - FSM not in IDLE
//   timeout              - one-cycle pulse when a write frame is aborted
module host_byte_bridge
  import host_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [1:0]            byte_sel,
  output logic [7:0]            byte_wdata,
  output logic                  reg_we,
  input  logic [7:0]            byte_rdata,
  output logic                  busy,
  output logic                  timeout
);

  state_t     state;
  logic [1:0] lane;      // next write lane to be accepted
  logic       rx_fire;
  logic       tx_fire;
  logic       abort;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;

`ifdef HOST_BRIDGE_TIMEOUT_EN
  logic tmr_load;
  logic tmr_en;
  logic tmr_expired;

  // Restart on the write command and on every accepted data byte.
  assign tmr_load = rx_fire &&
                    (((state == IDLE) && rx_data[CMD_WR_BIT]) || (state == WR_DATA));
  assign tmr_en   = (state == WR_DATA);

  host_bridge_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // A byte presented in the abort cycle itself is dropped with the frame.
  assign abort   = tmr_expired && (state == WR_DATA);
  assign timeout = tmr_expired;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  // Bridge FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lane       <= 2'd0;
      rx_ready   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'd0;
      reg_addr   <= '0;
      byte_sel   <= 2'd0;
      byte_wdata <= 8'd0;
      reg_we     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (rx_fire) begin
            reg_addr <= rx_data[ADDR_WIDTH-1:0];
            byte_sel <= 2'd0;
            lane     <= 2'd0;
            busy     <= 1'b1;
            if (rx_data[CMD_WR_BIT]) begin
              state <= WR_DATA;
            end else begin
              state    <= RD_LOAD;
              rx_ready <= 1'b0;
            end
          end
        end

        WR_DATA: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_fire) begin
            // byte_sel tracks the lane being strobed, lane the next one.
            byte_wdata <= rx_data;
            byte_sel   <= lane;
            reg_we     <= 1'b1;
            lane       <= lane + 2'd1;
            if (lane == LANE_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        RD_LOAD: begin
          tx_data  <= byte_rdata;
          tx_valid <= 1'b1;
          state    <= RD_SEND;
        end

        RD_SEND: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            if (byte_sel == LANE_LAST) begin
              state    <= IDLE;
              busy     <= 1'b0;
              rx_ready <= 1'b1;
            end else begin
              byte_sel <= byte_sel + 2'd1;
              state    <= RD_LOAD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_byte_bridge.sv
// tb_host_byte_bridge: self-checking bench for host_byte_bridge.
// Provides a byte-enable register bank around the DUT and an expected-value
// image of the registers updated per frame from the bytes the bench sends.
module tb_host_byte_bridge;

  localparam int unsigned AW = 3;

  logic          clk;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic [AW-1:0] reg_addr;
  logic [1:0]    byte_sel;
  logic [7:0]    byte_wdata;
  logic          reg_we;
  logic [7:0]    byte_rdata;
  logic          busy;
  logic          timeout;

  int checks = 0;
  int passes = 0;

  logic [31:0] bank     [8] = '{default: 32'h0};
  logic [31:0] exp_regs [8] = '{default: 32'h0};

  host_byte_bridge #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .reg_addr   (reg_addr),
    .byte_sel   (byte_sel),
    .byte_wdata (byte_wdata),
    .reg_we     (reg_we),
    .byte_rdata (byte_rdata),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank the bridge drives.
  always @(posedge clk) begin
    if (reg_we) bank[reg_addr][8*byte_sel +: 8] <= byte_wdata;
  end
  assign byte_rdata = bank[reg_addr][8*byte_sel +: 8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte until accepted (bounded); returns cycles spent waiting.
  task automatic send_byte(input logic [7:0] b, output int waited);
    waited   = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 50) begin
      step();
      waited++;
    end
    if (waited >= 50) chk("rx_accept_timeout", 32'(waited), 32'd0);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk(tag, {6'd0, rx_ready, tx_valid, tx_data, reg_addr, byte_sel, byte_wdata,
              reg_we, busy, timeout}, 32'd0);
  endtask

  task automatic chk_bank();
    for (int i = 0; i < 8; i++) chk("bank", bank[i], exp_regs[i]);
  endtask

  task automatic wr_frame(input logic [7:0] cmd, input logic [31:0] data);
    logic [AW-1:0] a;
    int w;
    a = cmd[AW-1:0];
    send_byte(cmd, w);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    for (int l = 0; l < 4; l++) begin
      send_byte(data[8*l +: 8], w);
      chk("wr_nowait", 32'(w), 32'd0);
      chk("wr_strobe", {20'd0, reg_we, reg_addr, byte_sel, byte_wdata},
          {20'd0, 1'b1, a, 2'(l), data[8*l +: 8]});
    end
    chk("wr_done_idle", {31'd0, busy}, 32'd0);
    exp_regs[a] = data;
  endtask

  task automatic rd_frame(input logic [7:0] cmd, input int max_stall, input int bp_lane);
    logic [AW-1:0] a;
    logic [31:0]   e;
    int            w;
    int            stall;
    logic          hold;
    a = cmd[AW-1:0];
    e = exp_regs[a];
    send_byte(cmd, w);
    chk("rd_load", {29'd0, busy, rx_ready, tx_valid}, {29'd0, 3'b100});
    for (int l = 0; l < 4; l++) begin
      step();
      chk("rd_send", {20'd0, tx_valid, rx_ready, byte_sel, tx_data},
          {20'd0, 1'b1, 1'b0, 2'(l), e[8*l +: 8]});
      stall = (l == bp_lane) ? 10 : int'($urandom_range(max_stall, 0));
      hold  = 1'b1;
      for (int s = 0; s < stall; s++) begin
        step();
        if (!(tx_valid === 1'b1 && tx_data === e[8*l +: 8] &&
              byte_sel === 2'(l) && rx_ready === 1'b0 && reg_we === 1'b0)) hold = 1'b0;
      end
      if (stall > 0) chk("rd_hold", {31'd0, hold}, 32'd1);
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      if (l < 3) chk("rd_reload", {29'd0, tx_valid, busy, rx_ready}, {29'd0, 3'b010});
      else       chk("rd_end",    {29'd0, tx_valid, busy, rx_ready}, {29'd0, 3'b001});
    end
  endtask

  initial begin
    int            w;
    logic          ok;
    logic [31:0]   d;
    logic [7:0]    c;
    logic [AW-1:0] a;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;

    step();
    chk_outputs_reset("reset_c0");
    step();
    chk_outputs_reset("reset_c1");
    rst = 1'b0;
    step();
    chk("post_reset_ready", {30'd0, rx_ready, busy}, {30'd0, 2'b10});

    // Directed write, read with backpressure, address truncation.
    wr_frame(8'h82, 32'h44332211);
    step();
    chk("reg2_value", bank[2], 32'h44332211);
    rd_frame(8'h02, 0, 1);
    wr_frame(8'hFA, 32'hDEADBEEF);
    step();
    chk_bank();
    rd_frame(8'h02, 0, -1);

    // Back-to-back write frames with no idle gap.
    wr_frame(8'h85, 32'h01020304);
    wr_frame(8'h86, 32'hA5A55A5A);

    // Randomized frames with random upper command bits and read stalls.
    for (int i = 0; i < 16; i++) begin
      c = 8'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        wr_frame({1'b1, c[6:0]}, $urandom);
      end else begin
        rd_frame({1'b0, c[6:0]}, 3, -1);
      end
    end
    step();
    chk_bank();

    // Stalled write frame.
    send_byte(8'h81, w);
    send_byte(8'hAA, w);
    exp_regs[1][7:0] = 8'hAA;
`ifdef HOST_BRIDGE_TIMEOUT_EN
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (timeout !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      step();
    end
    chk("to_quiet", {31'd0, ok}, 32'd1);
    chk("to_pulse", {30'd0, timeout, busy}, {30'd0, 2'b11});
    step();
    chk("to_idle", {30'd0, timeout, busy}, {30'd0, 2'b00});
`else
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (timeout !== 1'b0 || busy !== 1'b1 || reg_we !== 1'b0 || rx_ready !== 1'b1) ok = 1'b0;
    end
    chk("no_to_wait", {31'd0, ok}, 32'd1);
    d = $urandom;
    for (int l = 1; l < 4; l++) begin
      send_byte(d[8*l +: 8], w);
      chk("resume_strobe", {20'd0, reg_we, reg_addr, byte_sel, byte_wdata},
          {20'd0, 1'b1, 3'd1, 2'(l), d[8*l +: 8]});
      exp_regs[1][8*l +: 8] = d[8*l +: 8];
    end
    chk("resume_idle", {31'd0, busy}, 32'd0);
`endif
    step();
    chk_bank();

    // Reset in the middle of a write frame after two data bytes.
    a = 3'd3;
    send_byte(8'h83, w);
    send_byte(8'hC1, w);
    send_byte(8'hC2, w);
    exp_regs[a][15:0] = 16'hC2C1;
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    step();
    chk_outputs_reset("midframe_reset");
    rst      = 1'b0;
    rx_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (reg_we !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("after_reset_quiet", {31'd0, ok}, 32'd1);
    chk_bank();
    wr_frame(8'h83, 32'h13572468);
    rd_frame(8'h03, 2, -1);
    step();
    chk_bank();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
